// File: rtl/score_packer.sv
// Collects NUM_CLASSES signed scores into one packed frame and holds it until downstream takes it.
// Define SCORE_PACKER_RUNMAX_EN to also track the frame's argmax on Index while scores arrive.
module score_packer #(
    parameter int NUM_CLASSES = 10,
    parameter int WIDTH       = 26
) (
    input  logic                         clk,
    input  logic                         GlobalReset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_score,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CLASSES*WIDTH-1:0] Num,
    output logic [3:0]                   Index
);

    localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_CLASSES - 1);

    localparam logic FILL = 1'b0;
    localparam logic FULL = 1'b1;

    logic                         state_q, state_d;
    logic [CW-1:0]                count_q, count_d;
    logic [NUM_CLASSES*WIDTH-1:0] num_q, num_d;
    logic                         accept;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign Num       = num_q;
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        num_d   = num_q;
        if (flush) begin
            state_d = FILL;
            count_d = '0;
        end else if (state_q == FILL) begin
            if (accept) begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    if (count_q == CW'(k)) num_d[k*WIDTH +: WIDTH] = in_score;
                end
                if (count_q == LAST) begin
                    state_d = FULL;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end else if (out_ready) begin
            state_d = FILL;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q <= FILL;
            count_q <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            num_q   <= num_d;
        end
    end

`ifdef SCORE_PACKER_RUNMAX_EN
    logic [WIDTH-1:0] best_q, best_d;
    logic [3:0]       idx_q, idx_d;

    // Strict greater-than so ties keep the lower slot; slot 0 always seeds the search.
    always_comb begin
        best_d = best_q;
        idx_d  = idx_q;
        if (accept && ((count_q == '0) || ($signed(in_score) > $signed(best_q)))) begin
            best_d = in_score;
            idx_d  = 4'(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            best_q <= '0;
            idx_q  <= '0;
        end else begin
            best_q <= best_d;
            idx_q  <= idx_d;
        end
    end

    assign Index = idx_q;
`else
    assign Index = '0;
`endif

endmodule

// File: tb/tb_score_packer.sv
// Directed bench for score_packer: frame packing, hold/backpressure, flush, reset and argmax.
module tb_score_packer;
    localparam int NC = 10;
    localparam int W  = 26;
`ifdef SCORE_PACKER_RUNMAX_EN
    localparam bit RUNMAX = 1'b1;
`else
    localparam bit RUNMAX = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          GlobalReset, in_valid, flush, out_ready;
    logic [W-1:0]  in_score;
    logic          in_ready, out_valid;
    logic [NC*W-1:0] num;
    logic [3:0]    idx;

    int n_chk  = 0;
    int n_pass = 0;

    score_packer #(.NUM_CLASSES(NC), .WIDTH(W)) dut (
        .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready),
        .in_score(in_score), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .Num(num), .Index(idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] slot(input int k);
        return 64'(num[k*W +: W]);
    endfunction

    function automatic logic [63:0] sv(input int v);
        logic [W-1:0] t;
        t = v[W-1:0];
        return 64'(t);
    endfunction

    function automatic logic [63:0] ei(input int i);
        return RUNMAX ? 64'(i) : 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send10(input int s [NC]);
        chk("send_ir", 64'(in_ready), 64'd1);
        for (int i = 0; i < NC; i++) begin
            in_valid = 1'b1;
            in_score = s[i][W-1:0];
            tick();
            if (i == NC-2) chk("pre_last_ov", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;
        chk("frame_ov", 64'(out_valid), 64'd1);
        chk("frame_ir", 64'(in_ready), 64'd0);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_ov", 64'(out_valid), 64'd0);
        chk("pop_ir", 64'(in_ready), 64'd1);
    endtask

    initial begin
        GlobalReset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_score = '0;
        tick(); tick();
        GlobalReset = 1'b0;
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_ir", 64'(in_ready), 64'd1);
        chk("rst_num", 64'(|num), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);

        // out_ready while filling must be ignored
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send10('{-10, -15, -2, -100, -30, -10000, 200, -301234, -10000, -69});
        chk("f1_s0", slot(0), sv(-10));
        chk("f1_s6", slot(6), sv(200));
        chk("f1_s7", slot(7), sv(-301234));
        chk("f1_s9", slot(9), sv(-69));
        chk("f1_idx", 64'(idx), ei(6));

        // hold 5 cycles with in_valid asserted; nothing may change
        in_valid = 1'b1; in_score = sv(12345);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold_ov", 64'(out_valid), 64'd1);
            chk("hold_ir", 64'(in_ready), 64'd0);
            chk("hold_s0", slot(0), sv(-10));
            chk("hold_idx", 64'(idx), ei(6));
        end
        in_valid = 1'b0;
        pop();
        chk("trans_s6", slot(6), sv(200));

        send10('{5, 5, 5, 5, 5, 5, 5, 5, 5, 5});
        chk("eq5_s0", slot(0), sv(5));
        chk("eq5_s6", slot(6), sv(5));
        chk("eq5_idx", 64'(idx), ei(0));
        pop();

        send10('{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1});
        chk("eqm1_idx", 64'(idx), ei(0));
        pop();

        send10('{-33554432, -33554431, -33554431, -33554431, -33554431,
                 -33554431, -33554431, -33554431, -33554431, -33554431});
        chk("min_s0", slot(0), sv(-33554432));
        chk("min_idx", 64'(idx), ei(1));
        pop();

        // flush after 4 accepts, with a 5th score presented the same cycle
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_score = sv(100 + i); tick();
        end
        in_score = sv(999); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_ov", 64'(out_valid), 64'd0);
        chk("flush_ir", 64'(in_ready), 64'd1);
        send10('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        chk("fl_s0", slot(0), sv(1));
        chk("fl_s4", slot(4), sv(5));
        chk("fl_s9", slot(9), sv(10));
        chk("fl_idx", 64'(idx), ei(9));

        // flush dropping a held frame, with out_ready also high
        flush = 1'b1; out_ready = 1'b1; tick();
        flush = 1'b0; out_ready = 1'b0;
        chk("flfull_ov", 64'(out_valid), 64'd0);
        chk("flfull_ir", 64'(in_ready), 64'd1);

        // reset mid-frame after 7 accepts
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_score = sv(300 + i); tick();
        end
        GlobalReset = 1'b1; tick();
        GlobalReset = 1'b0; in_valid = 1'b0;
        chk("rst7_num", 64'(|num), 64'd0);
        chk("rst7_idx", 64'(idx), 64'd0);
        chk("rst7_ov", 64'(out_valid), 64'd0);
        chk("rst7_ir", 64'(in_ready), 64'd1);

        // reset while FULL, competing with out_ready and flush
        send10('{9, 8, 70, 6, 5, 4, 3, 2, 1, 0});
        chk("r_idx", 64'(idx), ei(2));
        GlobalReset = 1'b1; out_ready = 1'b1; flush = 1'b1; tick();
        GlobalReset = 1'b0; out_ready = 1'b0; flush = 1'b0;
        chk("rstf_num", 64'(|num), 64'd0);
        chk("rstf_idx", 64'(idx), 64'd0);
        chk("rstf_ov", 64'(out_valid), 64'd0);
        chk("rstf_ir", 64'(in_ready), 64'd1);

        // in_valid toggling: 10 accepts over 19 cycles
        for (int c = 0; c < 19; c++) begin
            in_valid = (c % 2 == 0);
            in_score = in_valid ? sv(50 + c / 2) : sv(7777);
            tick();
            if (c == 17) chk("tog_pre_ov", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;
        chk("tog_ov", 64'(out_valid), 64'd1);
        chk("tog_s0", slot(0), sv(50));
        chk("tog_s9", slot(9), sv(59));
        chk("tog_idx", 64'(idx), ei(9));
        pop();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
